// File: rtl/z80_bus_pkg.sv
// Shared types and helpers for the Z80 bus arbiter: ownership states,
// wait-counter width and the per-access-type wait-state selector.
package z80_bus_pkg;

  typedef enum logic [1:0] {
    CPU_OWN,
    DMA_OWN,
    DMA_XFER
  } arb_state_e;

  localparam int WS_W = 4;

  function automatic logic [WS_W-1:0] ws_sel(input logic            is_io,
                                             input logic [WS_W-1:0] mem_ws,
                                             input logic [WS_W-1:0] io_ws);
    return is_io ? io_ws : mem_ws;
  endfunction

endpackage

// File: rtl/z80_ws_counter.sv
// Wait-state down counter shared by CPU and DMA accesses: load has priority,
// otherwise it decrements toward zero and holds there.
module z80_ws_counter
  import z80_bus_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [WS_W-1:0] load_val,
  output logic [WS_W-1:0] cnt,
  output logic            zero
);

  logic [WS_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/z80_bus_arb.sv
// Bus arbiter / wait-state generator between the NextZ80 core and one DMA master.
// Optional burst limit (DMA_MAX_BURST transfers per grant) via Z80_BUS_ARB_BURST_LIMIT_EN.
module z80_bus_arb
  import z80_bus_pkg::*;
#(
  parameter int MEM_WS        = 1,
  parameter int IO_WS         = 2,
  parameter int DMA_MAX_BURST = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] CPU_ADDR,
  input  logic [7:0]  CPU_DO,
  input  logic        CPU_WR,
  input  logic        CPU_MREQ,
  input  logic        CPU_IORQ,
  output logic        CPU_WAIT,
  input  logic        DMA_REQ,
  input  logic [15:0] DMA_ADDR,
  input  logic [7:0]  DMA_DO,
  input  logic        DMA_WR,
  input  logic        DMA_IO,
  output logic        DMA_GNT,
  output logic        DMA_ACK,
  output logic [7:0]  DMA_DI,
  output logic [15:0] BUS_ADDR,
  output logic [7:0]  BUS_DO,
  output logic        BUS_WR,
  output logic        BUS_MREQ,
  output logic        BUS_IORQ,
  input  logic [7:0]  BUS_DI,
  input  logic        BUS_RDY
);

  localparam logic [WS_W-1:0] MEM_WS_C = WS_W'(MEM_WS);
  localparam logic [WS_W-1:0] IO_WS_C  = WS_W'(IO_WS);

  arb_state_e      state_q, state_d;
  logic            strb_prev_q, strb_prev_d;
  logic [7:0]      di_q, di_d;
  logic [15:0]     addr_q;
  logic [7:0]      do_q;
  logic            wr_q, io_q;
  logic            lat_en, cnt_load, cnt_zero, ack, grant;
  logic [WS_W-1:0] cnt_val, cnt_unused, cpu_ws;
  logic            cpu_strb, burst_hit, block;

  assign cpu_strb = CPU_MREQ | CPU_IORQ;
  assign cpu_ws   = ws_sel(CPU_IORQ, MEM_WS_C, IO_WS_C);

  z80_ws_counter u_ws_counter (
    .clk      (CLK),
    .rst_n    (RESET),
    .load     (cnt_load),
    .load_val (cnt_val),
    .cnt      (cnt_unused),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    strb_prev_d = 1'b0;
    di_d        = di_q;
    lat_en      = 1'b0;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    ack         = 1'b0;
    CPU_WAIT    = 1'b0;
    BUS_ADDR    = CPU_ADDR;
    BUS_DO      = CPU_DO;
    BUS_WR      = CPU_WR;
    BUS_MREQ    = CPU_MREQ;
    BUS_IORQ    = CPU_IORQ;
    unique case (state_q)
      CPU_OWN: begin
        strb_prev_d = cpu_strb;
        if (cpu_strb && !strb_prev_q) begin
          // The start cycle already counts as the first wait cycle.
          cnt_load = 1'b1;
          cnt_val  = (cpu_ws == '0) ? '0 : cpu_ws - 1'b1;
          CPU_WAIT = (cpu_ws != '0) || !BUS_RDY;
        end else begin
          CPU_WAIT = cpu_strb && (!cnt_zero || !BUS_RDY);
        end
        if (!cpu_strb && DMA_REQ && !block) begin
          state_d = DMA_OWN;
        end
      end
      DMA_OWN: begin
        CPU_WAIT = cpu_strb;
        BUS_ADDR = addr_q;
        BUS_DO   = do_q;
        BUS_WR   = 1'b0;
        BUS_MREQ = 1'b0;
        BUS_IORQ = 1'b0;
        if (burst_hit || !DMA_REQ) begin
          state_d = CPU_OWN;
        end else begin
          lat_en   = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = ws_sel(DMA_IO, MEM_WS_C, IO_WS_C);
          state_d  = DMA_XFER;
        end
      end
      DMA_XFER: begin
        CPU_WAIT = cpu_strb;
        BUS_ADDR = addr_q;
        BUS_DO   = do_q;
        BUS_WR   = wr_q;
        BUS_MREQ = !io_q;
        BUS_IORQ = io_q;
        if (cnt_zero && BUS_RDY) begin
          ack     = 1'b1;
          state_d = DMA_OWN;
          if (!wr_q) begin
            di_d = BUS_DI;
          end
        end
      end
      default: state_d = CPU_OWN;
    endcase
    // While held in reset only the external ready may stall the core.
    if (!RESET) begin
      CPU_WAIT = cpu_strb && !BUS_RDY;
    end
  end

  assign grant = (state_q == CPU_OWN) && (state_d == DMA_OWN);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= CPU_OWN;
      strb_prev_q <= 1'b0;
      di_q        <= 8'h00;
    end else begin
      state_q     <= state_d;
      strb_prev_q <= strb_prev_d;
      di_q        <= di_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (lat_en) begin
      addr_q <= DMA_ADDR;
      do_q   <= DMA_DO;
      wr_q   <= DMA_WR;
      io_q   <= DMA_IO;
    end
  end

`ifdef Z80_BUS_ARB_BURST_LIMIT_EN
  logic [7:0] burst_q, burst_d;
  logic       block_q, block_d;

  always_comb begin
    burst_d = burst_q;
    if (grant) begin
      burst_d = 8'h00;
    end else if (ack) begin
      burst_d = burst_q + 8'h01;
    end
    // One-cycle block lets a CPU access stalled by the burst win before regrant.
    block_d = (state_q == DMA_OWN) && burst_hit;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      burst_q <= 8'h00;
      block_q <= 1'b0;
    end else begin
      burst_q <= burst_d;
      block_q <= block_d;
    end
  end

  assign burst_hit = (burst_q == 8'(DMA_MAX_BURST));
  assign block     = block_q;
`else
  logic burst_cfg_unused;
  assign burst_cfg_unused = |{8'(DMA_MAX_BURST), grant, cnt_unused};
  assign burst_hit        = 1'b0;
  assign block            = 1'b0;
`endif

  assign DMA_GNT = (state_q != CPU_OWN);
  assign DMA_ACK = ack;
  assign DMA_DI  = di_q;

endmodule

// File: tb/tb_z80_bus_arb.sv
// Directed bench for z80_bus_arb (MEM_WS=1, IO_WS=2); burst-limit scenario
// follows Z80_BUS_ARB_BURST_LIMIT_EN.
module tb_z80_bus_arb;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] CPU_ADDR;
  logic [7:0]  CPU_DO;
  logic        CPU_WR, CPU_MREQ, CPU_IORQ;
  logic        CPU_WAIT;
  logic        DMA_REQ;
  logic [15:0] DMA_ADDR;
  logic [7:0]  DMA_DO;
  logic        DMA_WR, DMA_IO;
  logic        DMA_GNT, DMA_ACK;
  logic [7:0]  DMA_DI;
  logic [15:0] BUS_ADDR;
  logic [7:0]  BUS_DO;
  logic        BUS_WR, BUS_MREQ, BUS_IORQ;
  logic [7:0]  BUS_DI;
  logic        BUS_RDY;

  int n_vec  = 0;
  int n_miss = 0;

`ifdef Z80_BUS_ARB_BURST_LIMIT_EN
  localparam int MAXB = 4;
`else
  localparam int MAXB = 16;
`endif

  z80_bus_arb #(.MEM_WS(1), .IO_WS(2), .DMA_MAX_BURST(MAXB)) dut (
    .CLK(CLK), .RESET(RESET),
    .CPU_ADDR(CPU_ADDR), .CPU_DO(CPU_DO), .CPU_WR(CPU_WR),
    .CPU_MREQ(CPU_MREQ), .CPU_IORQ(CPU_IORQ), .CPU_WAIT(CPU_WAIT),
    .DMA_REQ(DMA_REQ), .DMA_ADDR(DMA_ADDR), .DMA_DO(DMA_DO),
    .DMA_WR(DMA_WR), .DMA_IO(DMA_IO), .DMA_GNT(DMA_GNT),
    .DMA_ACK(DMA_ACK), .DMA_DI(DMA_DI),
    .BUS_ADDR(BUS_ADDR), .BUS_DO(BUS_DO), .BUS_WR(BUS_WR),
    .BUS_MREQ(BUS_MREQ), .BUS_IORQ(BUS_IORQ), .BUS_DI(BUS_DI),
    .BUS_RDY(BUS_RDY)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    RESET = 1'b0;
    CPU_ADDR = 16'hBEEF; CPU_DO = 8'h00; CPU_WR = 1'b0;
    CPU_MREQ = 1'b1; CPU_IORQ = 1'b0;
    DMA_REQ = 1'b0; DMA_ADDR = 16'h0000; DMA_DO = 8'h00;
    DMA_WR = 1'b0; DMA_IO = 1'b0;
    BUS_DI = 8'h00; BUS_RDY = 1'b0;

    // Reset: outputs idle, BUS mirrors CPU, WAIT only from BUS_RDY
    #3;
    check_eq("rst_wait_rdy0", CPU_WAIT, 1);
    check_eq("rst_addr", BUS_ADDR, 16'hBEEF);
    check_eq("rst_mreq", BUS_MREQ, 1);
    check_eq("rst_gnt", DMA_GNT, 0);
    check_eq("rst_ack", DMA_ACK, 0);
    check_eq("rst_di", DMA_DI, 8'h00);
    BUS_RDY = 1'b1;
    #1;
    check_eq("rst_wait_rdy1", CPU_WAIT, 0);
    tick();
    CPU_MREQ = 1'b0;
    tick();
    RESET = 1'b1;

    // CPU memory read, MEM_WS=1: WAIT in start cycle only
    tick();
    CPU_ADDR = 16'h4000; CPU_MREQ = 1'b1;
    #1;
    check_eq("mem_wait_c0", CPU_WAIT, 1);
    check_eq("mem_busmreq", BUS_MREQ, 1);
    check_eq("mem_busaddr", BUS_ADDR, 16'h4000);
    tick();
    check_eq("mem_wait_c1", CPU_WAIT, 0);
    check_eq("mem_busmreq_c1", BUS_MREQ, 1);
    tick();
    CPU_MREQ = 1'b0;
    #1;
    check_eq("mem_busmreq_off", BUS_MREQ, 0);

    // CPU IO write, IO_WS=2, BUS_RDY low for 3 cycles
    tick();
    CPU_IORQ = 1'b1; CPU_WR = 1'b1; CPU_DO = 8'h5A; BUS_RDY = 1'b0;
    #1;
    check_eq("io_wait_c0", CPU_WAIT, 1);
    tick();
    check_eq("io_wait_c1", CPU_WAIT, 1);
    tick();
    check_eq("io_wait_c2", CPU_WAIT, 1);
    tick();
    BUS_RDY = 1'b1;
    #1;
    check_eq("io_wait_c3", CPU_WAIT, 0);
    check_eq("io_busiorq", BUS_IORQ, 1);
    check_eq("io_buswr", BUS_WR, 1);
    check_eq("io_busdo", BUS_DO, 8'h5A);
    tick();
    CPU_IORQ = 1'b0; CPU_WR = 1'b0;

    // DMA read of 0x1234, BUS_DI=0xA5
    tick();
    DMA_REQ = 1'b1; DMA_ADDR = 16'h1234; DMA_WR = 1'b0; DMA_IO = 1'b0; BUS_DI = 8'hA5;
    #1;
    check_eq("dma_gnt_idle", DMA_GNT, 0);
    tick();
    check_eq("dma_gnt", DMA_GNT, 1);
    check_eq("dma_own_mreq", BUS_MREQ, 0);
    tick();
    check_eq("dma_x1_mreq", BUS_MREQ, 1);
    check_eq("dma_x1_addr", BUS_ADDR, 16'h1234);
    check_eq("dma_x1_ack", DMA_ACK, 0);
    DMA_REQ = 1'b0;
    #1;
    tick();
    check_eq("dma_x2_mreq", BUS_MREQ, 1);
    check_eq("dma_x2_ack", DMA_ACK, 1);
    tick();
    check_eq("dma_di", DMA_DI, 8'hA5);
    check_eq("dma_ack_off", DMA_ACK, 0);
    check_eq("dma_gnt_hold", DMA_GNT, 1);
    tick();
    check_eq("dma_gnt_rel", DMA_GNT, 0);

    // CPU MREQ during DMA ownership stays stalled until release
    tick();
    DMA_REQ = 1'b1; DMA_ADDR = 16'h2222;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) begin
        CPU_MREQ = 1'b1; CPU_ADDR = 16'h8000;
      end
      if (k == 5) DMA_REQ = 1'b0;
      #1;
      check_eq("cont_wait", CPU_WAIT, 1);
      if (k == 1 || k == 4) check_eq("cont_busaddr", BUS_ADDR, 16'h2222);
      if (k == 2 || k == 5) check_eq("cont_ack", DMA_ACK, 1);
    end
    tick();
    check_eq("cont_wait_own", CPU_WAIT, 1);
    check_eq("cont_gnt_own", DMA_GNT, 1);
    tick();
    check_eq("cont_gnt_rel", DMA_GNT, 0);
    check_eq("cont_cpu_wait", CPU_WAIT, 1);
    check_eq("cont_cpu_addr", BUS_ADDR, 16'h8000);
    tick();
    check_eq("cont_cpu_done", CPU_WAIT, 0);
    tick();
    CPU_MREQ = 1'b0;

`ifdef Z80_BUS_ARB_BURST_LIMIT_EN
    // Burst limit 4 with a CPU access pending
    tick();
    DMA_REQ = 1'b1; DMA_ADDR = 16'h3000;
    tick();
    CPU_MREQ = 1'b1; CPU_ADDR = 16'h9000;
    #1;
    acks = 0;
    for (int i = 0; i < 40 && DMA_GNT; i++) begin
      if (DMA_ACK) acks++;
      tick();
    end
    check_eq("burst_acks", acks, 4);
    check_eq("burst_gnt_drop", DMA_GNT, 0);
    check_eq("burst_cpu_wait", CPU_WAIT, 1);
    check_eq("burst_cpu_addr", BUS_ADDR, 16'h9000);
    tick();
    check_eq("burst_cpu_done", CPU_WAIT, 0);
    tick();
    CPU_MREQ = 1'b0;
    #1;
    check_eq("burst_gnt_idle", DMA_GNT, 0);
    tick();
    check_eq("burst_regrant", DMA_GNT, 1);
    DMA_REQ = 1'b0;
    tick();
    check_eq("burst_rel", DMA_GNT, 0);
`else
    // No burst limit: DMA keeps the bus, one transfer per 3 cycles
    tick();
    DMA_REQ = 1'b1; DMA_ADDR = 16'h3000;
    acks = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (DMA_ACK) acks++;
    end
    check_eq("hold_acks", acks, 4);
    check_eq("hold_gnt", DMA_GNT, 1);
    tick();
    DMA_REQ = 1'b0;
    #1;
    check_eq("hold_gnt_own", DMA_GNT, 1);
    tick();
    check_eq("hold_rel", DMA_GNT, 0);
`endif

    // Reset during an IO write transfer
    tick();
    CPU_ADDR = 16'h0ABC;
    DMA_REQ = 1'b1; DMA_ADDR = 16'h3333; DMA_IO = 1'b1; DMA_WR = 1'b1; DMA_DO = 8'h77;
    tick();
    tick();
    check_eq("rx_iorq", BUS_IORQ, 1);
    check_eq("rx_mreq", BUS_MREQ, 0);
    check_eq("rx_wr", BUS_WR, 1);
    check_eq("rx_do", BUS_DO, 8'h77);
    check_eq("rx_addr", BUS_ADDR, 16'h3333);
    RESET = 1'b0; DMA_REQ = 1'b0;
    #1;
    check_eq("rx_gnt", DMA_GNT, 0);
    check_eq("rx_ack", DMA_ACK, 0);
    check_eq("rx_di", DMA_DI, 8'h00);
    check_eq("rx_iorq_off", BUS_IORQ, 0);
    tick();
    RESET = 1'b1;
    tick();
    check_eq("rx_post_gnt", DMA_GNT, 0);
    check_eq("rx_post_addr", BUS_ADDR, 16'h0ABC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
